ha_serial_adder_seq: RTL and testbench

Bit-serial add sequencer that feeds the design's half-adder datapath with multi-bit operands. It accepts two WIDTH-bit operands over a valid/ready handshake and iterates a one-bit add cell LSB-first, one bit per clock, with a registered carry. It presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. In the top-level wrapper it sits between the dedicated inputs (operand capture) and the dedicated outputs (result display).

---
 rtl/ha_serial_adder_seq.sv | 157 +++++++++++++++
 tb/tb_ha_serial_adder_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ha_serial_adder_seq.sv
// ha_serial_adder_seq: bit-serial add sequencer around a one-bit add cell.
// Accepts two WIDTH-bit operands and processes them LSB-first, one bit per
// clock. Produces either a full add with a carry chain or a carry-less add,
// then holds the result until the consumer takes it.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair valid            in_ready   accepting (IDLE only)
//   a, b       WIDTH-bit operands            mode       0 = add, 1 = carry-less
//   out_valid  result valid (DONE only)      out_ready  consumer accepts result
//   sum        WIDTH-bit result              cout       carry-out / any-carry flag
//   busy       high while bits are being processed
//   op_count   completed operations, wraps at 256
module ha_serial_adder_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [7:0]       op_count
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mreg_q;
  logic             c_q;
  logic             g_q;

  logic             accept;
  logic             last_bit;
  logic             retire;

  logic             x;
  logic             y;
  logic             s_bit;
  logic             c_nxt;
  logic             g_nxt;
  logic [WIDTH-1:0] sr_nxt;

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_BIT) begin
          last_bit = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-bit add cell; the carry is masked off in carry-less mode.
  always_comb begin
    x      = sa_q[0];
    y      = sb_q[0];
    s_bit  = x ^ y ^ (c_q & ~mreg_q);
    c_nxt  = mreg_q ? 1'b0 : ((x & y) | (c_q & (x ^ y)));
    g_nxt  = g_q | (x & y);
    sr_nxt = {s_bit, sr_q[WIDTH-1:1]};
  end

  // State, registered handshake flags and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sa_q      <= '0;
      sb_q      <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      mreg_q    <= 1'b0;
      c_q       <= 1'b0;
      g_q       <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      op_count  <= 8'd0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == S_IDLE);
      busy      <= (state_d == S_RUN);
      out_valid <= (state_d == S_DONE);

      if (accept) begin
        sa_q   <= a;
        sb_q   <= b;
        mreg_q <= mode;
        c_q    <= 1'b0;
        g_q    <= 1'b0;
        sr_q   <= '0;
        cnt_q  <= '0;
      end

      if (state_q == S_RUN) begin
        sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
        sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
        sr_q  <= sr_nxt;
        c_q   <= c_nxt;
        g_q   <= g_nxt;
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // Result registers load once, from the final bit's cell outputs.
      if (last_bit) begin
        sum  <= sr_nxt;
        cout <= mreg_q ? g_nxt : c_nxt;
      end

      if (retire) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ha_serial_adder_seq.sv
// Self-checking bench for ha_serial_adder_seq (WIDTH = 8): directed cases,
// back-pressure, mid-operation reset and a randomized run with a golden model.
module tb_ha_serial_adder_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic [7:0]       op_count;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_cnt = 8'd0;

  ha_serial_adder_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Golden model: {cout, sum}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                          input logic m);
    if (m) return {|(av & bv), av ^ bv};
    return {1'b0, av} + {1'b0, bv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, then presents the operands for one accept edge.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic m);
    int k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    mode     = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    mode     = 1'($urandom);
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!out_valid && cycles < 50) begin
      if (busy) busy_cycles++;
      tick();
      cycles++;
    end
    check("out_valid_rise", 32'(out_valid), 32'd1);
  endtask

  // Holds out_ready low for 'stall' cycles, checks the result, then retires it.
  task automatic finish_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic m, input int stall);
    logic [WIDTH:0] exp;
    exp = model(av, bv, m);
    for (int i = 0; i < stall; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'(exp[WIDTH-1:0]));
      tick();
    end
    check("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
    check("cout", 32'(cout), 32'(exp[WIDTH]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 8'd1;
    check("op_count", 32'(op_count), 32'(exp_cnt));
    check("out_valid_fall", 32'(out_valid), 32'd0);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic m);
    int cyc;
    int bcyc;
    start_op(av, bv, m);
    wait_done(cyc, bcyc);
    finish_op(av, bv, m, 0);
  endtask

  initial begin
    int cyc;
    int bcyc;
    logic seen_valid;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rm;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);

    // Reset during the third RUN cycle aborts the operation.
    start_op(8'hAA, 8'h55, 1'b0);
    tick();
    tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_op_count", 32'(op_count), 32'(exp_cnt));
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen_valid = 1'b1;
      tick();
    end
    check("abort_no_result", 32'(seen_valid), 32'd0);
    do_op(8'h01, 8'h02, 1'b0);

    // Latency and busy window.
    start_op(8'h5A, 8'h3C, 1'b0);
    check("accept_in_ready", 32'(in_ready), 32'd0);
    wait_done(cyc, bcyc);
    check("latency", 32'(cyc), 32'(WIDTH));
    check("busy_cycles", 32'(bcyc), 32'(WIDTH));
    finish_op(8'h5A, 8'h3C, 1'b0, 0);

    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'h00, 8'h00, 1'b0);
    do_op(8'h5A, 8'h3C, 1'b1);
    do_op(8'hF0, 8'h0F, 1'b1);

    // Back-pressure with a competing in_valid.
    start_op(8'h80, 8'h80, 1'b0);
    wait_done(cyc, bcyc);
    a = 8'h11; b = 8'h22; mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_sum", 32'(sum), 32'h00);
      check("bp_cout", 32'(cout), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt   = exp_cnt + 8'd1;
    check("bp_op_count", 32'(op_count), 32'(exp_cnt));
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'd1);
    wait_done(cyc, bcyc);
    finish_op(8'h11, 8'h22, 1'b0, 0);

    // Randomized run from a fresh reset; 256 operations wrap op_count to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    for (int n = 0; n < 256; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rm = 1'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      start_op(ra, rb, rm);
      wait_done(cyc, bcyc);
      check("rnd_latency", 32'(cyc), 32'(WIDTH));
      finish_op(ra, rb, rm, int'($urandom_range(0, 3)));
    end
    check("wrap_op_count", 32'(op_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
